// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART types, oversampling constants and helpers
// Rev 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_t;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_T0  = 4'd7;
    localparam logic [3:0] SAMPLE_T1  = 4'd8;
    localparam logic [3:0] SAMPLE_T2  = 4'd9;
    localparam int         DATA_BITS  = 8;

    localparam logic [3:0] c_last_tick = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] c_last_bit  = 3'(DATA_BITS - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
// uart_rx_core_if : byte handshake and sticky-flag bus of the UART receiver
// Rev 1.0
// ============================================================================
interface uart_rx_core_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready,
        input  err_clr
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready,
        output err_clr
    );

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// uart_baud_tick : reloadable down-counter emitting one tick every i_div+1 clocks
// Rev 1.0
// ============================================================================
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load || o_tick) begin
            r_cnt <= i_div;
        end else if (i_en) begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// uart_rx_core : 16x oversampling 8N1 receiver with majority vote and one-entry holding register
// Rev 1.0
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
    output logic             busy,
    uart_rx_core_if.master   bus
);

    uart_rx_state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_prev;
    logic [DIV_W-1:0]       r_div_q;
    logic [3:0]             r_tick_idx;
    logic [1:0]             r_samp;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic             w_rxs, w_fall, w_start_frame, w_tick, w_maj, w_hs;
    logic             w_decide, w_bit_end;
    logic [3:0]       w_tick_num;
    logic [DIV_W-1:0] w_div;
    logic             w_load_byte, w_set_ovr, w_set_ferr, w_shift_bit;

    assign w_rxs         = r_sync[SYNC_STAGES-1];
    assign w_fall        = r_rxs_prev & ~w_rxs;
    assign w_start_frame = (r_state == IDLE) && w_fall;
    // Tick numbering: the tick that advances the index to N is "tick N".
    assign w_tick_num    = r_tick_idx + 4'd1;
    assign w_decide      = w_tick && (w_tick_num == SAMPLE_T2);
    assign w_bit_end     = w_tick && (w_tick_num == c_last_tick);
    assign w_maj         = majority3(r_samp[0], r_samp[1], w_rxs);
    assign w_hs          = r_rx_valid & bus.rx_ready;
    // The live divisor is only used for the initial load; reloads use the latched copy.
    assign w_div         = (r_state == IDLE) ? baud_div : r_div_q;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk    (clk_sys),
        .rst_n  (rst_sys_n),
        .i_load (w_start_frame),
        .i_en   (r_state != IDLE),
        .i_div  (w_div),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_byte = 1'b0;
        w_set_ovr   = 1'b0;
        w_set_ferr  = 1'b0;
        w_shift_bit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) w_state_nxt = START;
            end
            START: begin
                if (w_decide && w_maj)  w_state_nxt = IDLE;
                else if (w_bit_end)     w_state_nxt = DATA;
            end
            DATA: begin
                w_shift_bit = w_decide;
                if (w_bit_end && (r_bit_cnt == c_last_bit)) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_decide) begin
                    if (!w_maj) begin
                        w_set_ferr  = 1'b1;
                        w_state_nxt = WAIT_HIGH;
                    end else if (!r_rx_valid || bus.rx_ready) begin
                        w_load_byte = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_set_ovr   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (w_rxs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            r_sync      <= '1;
            r_rxs_prev  <= 1'b1;
            r_div_q     <= '0;
            r_tick_idx  <= '0;
            r_samp      <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rxs_prev <= w_rxs;

            if (w_start_frame) begin
                r_div_q    <= baud_div;
                r_tick_idx <= '0;
                r_bit_cnt  <= '0;
            end else begin
                if (w_tick) r_tick_idx <= w_tick_num;
                if ((r_state == DATA) && w_bit_end) r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_tick && (w_tick_num == SAMPLE_T0)) r_samp[0] <= w_rxs;
            if (w_tick && (w_tick_num == SAMPLE_T1)) r_samp[1] <= w_rxs;
            if (w_shift_bit) r_shift <= {w_maj, r_shift[7:1]};

            // A load in the handshake cycle keeps valid high with the new byte.
            if (w_load_byte) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (w_hs) begin
                r_rx_valid <= 1'b0;
            end

            if (w_set_ferr)       r_frame_err <= 1'b1;
            else if (bus.err_clr) r_frame_err <= 1'b0;
            if (w_set_ovr)        r_overrun   <= 1'b1;
            else if (bus.err_clr) r_overrun   <= 1'b0;
        end
    end

    assign busy          = (r_state != IDLE);
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
# uart_rx_core

UART receiver core for the ibex system peripheral bus: the receive-side counterpart of the existing TX path on the top-level RX pin. It oversamples the asynchronous RX line at 16x the baud rate and recovers 8N1 frames using a majority vote. Each byte is delivered through a one-entry valid/ready holding register. Sticky framing-error and overrun flags are provided for the bus-side register wrapper.

## Interface
Parameters:
- DIV_W, 16, width of the baud divisor input.
- SYNC_STAGES, 2, number of flip-flops in the RX input synchronizer (minimum 2).

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst_sys_n  in  1  reset, synchronous, active-low.
- rx  in  1  asynchronous serial input; idles high.
- baud_div  in  DIV_W  oversample divisor: tick period = baud_div+1 clk_sys cycles, so baud = f_clk / (16·(baud_div+1)).
- rx_data  out  8  received byte, LSB first on the wire; valid while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts the byte in any cycle where rx_valid & rx_ready.
- frame_err  out  1  sticky: stop bit sampled low.
- overrun  out  1  sticky: a good frame completed while the holding register was full.
- err_clr  in  1  one-cycle pulse that clears frame_err and overrun.
- busy  out  1  high in any state other than IDLE.

## Operation
- rx passes through SYNC_STAGES flops and is then called rxs. The line is never sampled raw.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - A falling edge on rxs (previous 1, current 0) moves to START.
  - On that edge: the tick divider reloads, the tick index is cleared to 0, and baud_div is latched into div_q.
  - baud_div changes mid-frame have no effect on the current frame.
- Tick divider:
  - Down-counter loaded with div_q; it emits one tick when it reaches 0, then reloads.
  - It runs only outside IDLE.
- Bit timing:
  - A 4-bit tick index counts 0..15 within each bit.
  - rxs is sampled on ticks 7, 8 and 9; the bit value is the majority of the 3 samples and is decided on tick 9.
  - The bit ends after tick 15.
- START: if the majority is 1, the start is false; return to IDLE with no flags and no output. Otherwise continue to DATA when the bit ends.
- DATA:
  - Eight bits are shifted into the shift register LSB first.
  - A 3-bit counter tracks bits; after bit 7 ends, go to STOP.
- STOP (the decision is taken on tick 9; the state does not wait for tick 15):
  - Majority 1, holding register empty or being emptied this cycle: load rx_data and set rx_valid. Go to IDLE.
  - Majority 1, holding register full and rx_ready=0: set overrun. The new byte is discarded and the old rx_data is kept unchanged. Go to IDLE.
  - Majority 0: set frame_err; the byte is discarded. Go to WAIT_HIGH.
- WAIT_HIGH (break and line-stuck-low handling): stay until rxs=1, then go to IDLE. No restart occurs during a break.
- Handshake:
  - rx_valid clears on the cycle after a handshake (rx_valid & rx_ready), unless a new byte loads in that same cycle; rx_valid then stays 1 with the new rx_data.
  - rx_data is stable while rx_valid=1.
- Flags:
  - If err_clr is pulsed in the same cycle that a flag is being set, the set wins.
  - err_clr has no effect on rx_valid or rx_data.
- baud_div=0 is legal: one tick per clock, 16 clocks per bit.

## Timing
- Values after reset: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0, state IDLE.
- The synchronizer flops reset to 1, so no spurious edge is seen after reset.
- Reset mid-frame: everything returns to its reset value in the next cycle. The partial frame is lost and no flag is raised.
- Latency:
  - Falling edge on rx to busy=1: SYNC_STAGES+1 cycles.
  - START to stop decision: 153 ticks, i.e. 153·(div_q+1) cycles.
  - rx_valid rises 1 cycle after the stop-decision tick.
- Back-to-back frames: returning to IDLE at stop tick 9 leaves about 6 ticks of margin, so the next start edge is caught with no gap.

## Structure
- Shared package uart_pkg holds:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH};
  - OVERSAMPLE=16, SAMPLE_T0=7, SAMPLE_T1=8, SAMPLE_T2=9, DATA_BITS=8.
  - The TX core will later import the same package.
- One sub-module: uart_baud_tick (load/enable inputs, div input, tick output), reusable by the TX core.

## Test plan
All scenarios use clk_sys = 14.7456 MHz and baud_div=7 (115200 baud, 128 cycles per bit) unless stated.
- Basic byte: send 0xA5 with rx_ready=0.
  - rx_valid rises 1225±1 cycles after busy rises, with rx_data=0xA5.
  - Asserting rx_ready for one cycle clears rx_valid on the next cycle.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap and rx_ready=1.
  - Three valid pulses in order, with matching data.
  - frame_err=0 and overrun=0 throughout.
- Overrun: send 0x12 then 0x34 with rx_ready held 0.
  - rx_data stays 0x12 and overrun=1.
  - err_clr clears overrun.
- Simultaneous accept and load: rx_ready pulses on exactly the stop-decision cycle of a second frame.
  - rx_valid stays 1, rx_data becomes the new byte, overrun=0.
- Glitch and break:
  - A 3-cycle low pulse on rx gives no busy beyond START, no output and no flags.
  - A 2-frame-long break gives frame_err=1, state WAIT_HIGH until rx returns high, and no rx_valid.
  - Applying rst_sys_n=0 mid-frame clears all outputs.
- Jitter: baud_div=0 with ±3% bit-time skew on 0xC3 gives correct data and no frame_err.
